// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared decode constants, status bit positions and drain-state
// encoding for the memory-mapped IO hub.
package io_hub_pkg;

  // One-hot word-address select bits (word address = IO_memAddr[15:2])
  localparam int IO_LEDS_BIT      = 0;
  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_CTRL_BIT = 2;
  localparam int IO_TIMER_BIT     = 3;

  // UART_CTRL read-back bit positions
  localparam int ST_DONE    = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVF     = 10;
  localparam int ST_LVL_LSB = 16;
  localparam int ST_LVL_W   = 9;   // holds 0..256

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } drain_state_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with separate level counter. Pop and push in the
// same cycle are both honoured, even when full. No read bypass: a pushed
// entry is visible at the head one cycle after the push.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at power-of-two depth; level tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped IO hub (LEDs, TX FIFO in front of txuart, status,
// optional cycle counter). Define IO_HUB_TIMER_EN to build the 32-bit
// free-running counter readable at word bit 3; otherwise that word reads 0.
//
// Drain FSM states:
//   state | meaning
//   IDLE  | wait for FIFO non-empty and !uart_busy, then pop head to uart_data
//   SEND  | uart_wr high for exactly this cycle
//   HOLD  | ignore uart_busy for one cycle while txuart raises busy
module io_hub
  import io_hub_pkg::*;
#(
  parameter int LED_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IO_memAddr,
  input  logic [31:0]      IO_memWData,
  input  logic             IO_memWr,
  output logic [31:0]      IO_memRData,
  output logic [LED_W-1:0] leds,
  output logic             uart_wr,
  output logic [7:0]       uart_data,
  input  logic             uart_busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [13:0]      wa;
  logic             sel_leds;
  logic             sel_dat;
  logic             sel_ctrl;
  logic             sel_tmr;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic [LVL_W-1:0] level;
  drain_state_t     state;
  logic             ovf;
  logic             ovf_set;
  logic             ovf_clr;
  logic             done;
  logic [31:0]      status;
  logic [31:0]      timer_val;
  logic             unused_bits;

  assign wa       = IO_memAddr[15:2];
  assign sel_leds = wa[IO_LEDS_BIT];
  assign sel_dat  = wa[IO_UART_DAT_BIT];
  assign sel_ctrl = wa[IO_UART_CTRL_BIT];
  assign sel_tmr  = wa[IO_TIMER_BIT];

  // Address/data bits that are outside the decode or the used data fields
  assign unused_bits = ^{IO_memAddr[31:16], IO_memAddr[1:0], wa[13:4], IO_memWData};

  assign push    = IO_memWr & sel_dat;
  assign pop     = (state == IDLE) & ~fifo_empty & ~uart_busy;
  // A pop in the same cycle frees a slot, so only a truly blocked push overflows
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = IO_memWr & sel_ctrl & IO_memWData[ST_OVF];
  assign done    = fifo_empty & (state == IDLE) & ~uart_busy;

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (IO_memWData[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // LED register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    leds <= '0;
    else if (IO_memWr && sel_leds) leds <= IO_memWData[LED_W-1:0];
  end

  // Sticky overflow flag; a same-cycle overflow wins over a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Drain FSM with registered uart_wr / uart_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      uart_wr   <= 1'b0;
      uart_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_data <= fifo_head;
            uart_wr   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          uart_wr <= 1'b0;
          state   <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          uart_wr <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef IO_HUB_TIMER_EN
  // Free-running cycle counter, wraps at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_val <= '0;
    else        timer_val <= timer_val + 32'd1;
  end
`else
  assign timer_val = '0;
`endif

  // Status word and OR-combined read mux over all selected sources
  always_comb begin
    status                            = '0;
    status[ST_DONE]                   = done;
    status[ST_FULL]                   = fifo_full;
    status[ST_OVF]                    = ovf;
    status[ST_LVL_LSB +: ST_LVL_W]    = ST_LVL_W'(level);

    IO_memRData = '0;
    if (sel_leds) IO_memRData = IO_memRData | 32'(leds);
    if (sel_ctrl) IO_memRData = IO_memRData | status;
    if (sel_tmr)  IO_memRData = IO_memRData | timer_val;
  end

endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed self-checking bench for io_hub (LED_W=16, FIFO_DEPTH=16).
module tb_io_hub;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IO_memAddr = '0;
  logic [31:0] IO_memWData = '0;
  logic        IO_memWr = 1'b0;
  logic [31:0] IO_memRData;
  logic [15:0] leds;
  logic        uart_wr;
  logic [7:0]  uart_data;
  logic        uart_busy = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_hub #(
    .LED_W      (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IO_memAddr  (IO_memAddr),
    .IO_memWData (IO_memWData),
    .IO_memWr    (IO_memWr),
    .IO_memRData (IO_memRData),
    .leds        (leds),
    .uart_wr     (uart_wr),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IO_memAddr  = a;
    IO_memWData = d;
    IO_memWr    = 1'b1;
    cyc();
    IO_memWr    = 1'b0;
    IO_memAddr  = '0;
    IO_memWData = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IO_memAddr = a;
    #1;
    d = IO_memRData;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    total++; if (leds !== 16'h0) begin bad++; $display("FAIL reset_leds got=%h want=0000", leds); end
    total++; if (uart_wr !== 1'b0) begin bad++; $display("FAIL reset_uart_wr got=%b want=0", uart_wr); end
    total++; if (uart_data !== 8'h00) begin bad++; $display("FAIL reset_uart_data got=%h want=00", uart_data); end
    bus_read(32'h10, r);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL reset_ctrl got=%h want=00000100", r); end
    bus_read(32'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_nosel got=%h want=00000000", r); end
    bus_read(32'h8, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_dat_read got=%h want=00000000", r); end
  endtask

  task automatic test_leds();
    logic [31:0] r;
    IO_memAddr  = 32'h4;
    IO_memWData = 32'h0000_A5A5;
    IO_memWr    = 1'b1;
    #1;
    total++; if (leds !== 16'h0) begin bad++; $display("FAIL leds_before_edge got=%h want=0000", leds); end
    cyc();
    IO_memWr = 1'b0;
    total++; if (leds !== 16'hA5A5) begin bad++; $display("FAIL leds_a5a5 got=%h want=a5a5", leds); end
    bus_read(32'h4, r);
    total++; if (r !== 32'h0000_A5A5) begin bad++; $display("FAIL leds_read got=%h want=0000a5a5", r); end
    bus_write(32'h4, 32'hFFFF_1234);
    total++; if (leds !== 16'h1234) begin bad++; $display("FAIL leds_trunc got=%h want=1234", leds); end
    bus_read(32'h4, r);
    total++; if (r !== 32'h0000_1234) begin bad++; $display("FAIL leds_read_zext got=%h want=00001234", r); end
    bus_write(32'h0, 32'h0000_FFFF);
    total++; if (leds !== 16'h1234) begin bad++; $display("FAIL leds_nosel_write got=%h want=1234", leds); end
    bus_write(32'h40, 32'h0000_7777);
    total++; if (leds !== 16'h1234) begin bad++; $display("FAIL leds_undecoded_write got=%h want=1234", leds); end
    bus_write(32'h14, 32'h0000_0456);
    total++; if (leds !== 16'h0456) begin bad++; $display("FAIL leds_multisel_write got=%h want=0456", leds); end
    bus_read(32'h14, r);
    total++; if (r !== 32'h0000_0556) begin bad++; $display("FAIL multisel_read_or got=%h want=00000556", r); end
  endtask

  task automatic test_uart_single();
    logic [31:0] r;
    uart_busy = 1'b0;
    bus_write(32'h8, 32'h0000_0041);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0001_0000) begin bad++; $display("FAIL single_level1 got=%h want=00010000", r); end
    total++; if (uart_wr !== 1'b0) begin bad++; $display("FAIL single_wr_early got=%b want=0", uart_wr); end
    cyc();
    total++; if (uart_wr !== 1'b1) begin bad++; $display("FAIL single_wr_pulse got=%b want=1", uart_wr); end
    total++; if (uart_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want=41", uart_data); end
    uart_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++; if (uart_wr !== 1'b0) begin bad++; $display("FAIL single_wr_extra cyc=%0d got=%b want=0", i, uart_wr); end
      bus_read(32'h10, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL single_busy_ctrl cyc=%0d got=%h want=00000000", i, r); end
    end
    uart_busy = 1'b0;
    bus_read(32'h10, r);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL single_done got=%h want=00000100", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int pulses = 0;
    uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_write(32'h8, 32'h10 + i);
      if (uart_wr) pulses++;
    end
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0200) begin bad++; $display("FAIL ovf_full16 got=%h want=00100200", r); end
    bus_write(32'h8, 32'h20);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0600) begin bad++; $display("FAIL ovf_set got=%h want=00100600", r); end
    bus_write(32'h10, 32'h400);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0200) begin bad++; $display("FAIL ovf_clear got=%h want=00100200", r); end
    bus_write(32'h8, 32'h21);
    bus_write(32'h18, 32'h400);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0600) begin bad++; $display("FAIL ovf_set_beats_clear got=%h want=00100600", r); end
    bus_write(32'h10, 32'h0);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0600) begin bad++; $display("FAIL ovf_sticky got=%h want=00100600", r); end
    bus_write(32'h10, 32'h400);
    bus_read(32'h10, r);
    total++; if (r !== 32'h0010_0200) begin bad++; $display("FAIL ovf_clear2 got=%h want=00100200", r); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL ovf_busy_gating pulses=%0d want=0", pulses); end
  endtask

  task automatic test_drain();
    logic [31:0] r;
    int idx = 0;
    int last = -100;
    uart_busy = 1'b0;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      cyc();
      if (uart_busy && c >= last + 4) uart_busy = 1'b0;
      if (uart_wr) begin
        total++; if (uart_data !== 8'(8'h10 + idx)) begin bad++; $display("FAIL drain_order idx=%0d got=%h want=%h", idx, uart_data, 8'(8'h10 + idx)); end
        if (idx > 0) begin
          total++; if (c - last < 3) begin bad++; $display("FAIL drain_spacing idx=%0d got=%0d want>=3", idx, c - last); end
        end
        last = c;
        idx++;
        uart_busy = 1'b1;
      end
    end
    total++; if (idx !== 16) begin bad++; $display("FAIL drain_count got=%0d want=16", idx); end
    uart_busy = 1'b0;
    repeat (4) cyc();
    total++; if (uart_wr !== 1'b0) begin bad++; $display("FAIL drain_extra_wr got=%b want=0", uart_wr); end
    bus_read(32'h10, r);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL drain_final_ctrl got=%h want=00000100", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int pulses = 0;
    bus_write(32'h4, 32'h0000_BEEF);
    uart_busy = 1'b1;
    bus_write(32'h8, 32'h61);
    bus_write(32'h8, 32'h62);
    bus_write(32'h8, 32'h63);
    uart_busy = 1'b0;
    cyc();
    total++; if (uart_wr !== 1'b1 || uart_data !== 8'h61) begin bad++; $display("FAIL mid_first_byte wr=%b data=%h want wr=1 data=61", uart_wr, uart_data); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (uart_wr !== 1'b0) begin bad++; $display("FAIL mid_reset_wr got=%b want=0", uart_wr); end
    total++; if (uart_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h want=00", uart_data); end
    total++; if (leds !== 16'h0) begin bad++; $display("FAIL mid_reset_leds got=%h want=0000", leds); end
    bus_read(32'h10, r);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL mid_reset_ctrl got=%h want=00000100", r); end
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (uart_wr) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_reset_flushed pulses=%0d want=0", pulses); end
    bus_read(32'h10, r);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL mid_reset_after got=%h want=00000100", r); end
  endtask

  task automatic test_timer();
    logic [31:0] a;
    logic [31:0] b;
`ifdef IO_HUB_TIMER_EN
    bus_read(32'h20, a);
    repeat (5) cyc();
    bus_read(32'h20, b);
    total++; if (b - a !== 32'd5) begin bad++; $display("FAIL timer_delta got=%0d want=5", b - a); end
    bus_read(32'h20, a);
    bus_write(32'h20, 32'h0);
    repeat (4) cyc();
    bus_read(32'h20, b);
    total++; if (b - a !== 32'd5) begin bad++; $display("FAIL timer_write_ignored got=%0d want=5", b - a); end
`else
    bus_read(32'h20, a);
    total++; if (a !== 32'h0) begin bad++; $display("FAIL timer_off_read got=%h want=00000000", a); end
    bus_write(32'h20, 32'hFFFF_FFFF);
    repeat (3) cyc();
    bus_read(32'h20, b);
    total++; if (b !== 32'h0) begin bad++; $display("FAIL timer_off_after_write got=%h want=00000000", b); end
`endif
  endtask

  initial begin
    test_reset();
    test_leds();
    test_uart_single();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_hub.md
# io_hub

Parametrised memory-mapped IO hub between the Processor IO bus (`IO_memAddr`/`IO_memWData`/`IO_memWr`/`IO_memRData`) and the board peripherals. It is the next generation of the SOC's inline LED/UART decode: it adds a configurable LED width, LED readback, a TX byte FIFO in front of `txuart` with a drain state machine, a sticky overflow flag and a FIFO level readout. An optional free-running cycle counter is also available. It instantiates in the SOC in place of the ad-hoc decode logic.

## Interface
- `LED_W`, 16: LED register width, 1..32.
- `FIFO_DEPTH`, 16: TX FIFO entries, power of two, 2..256.
- `clk` in 1: system clock, from Clockworks `clk`.
- `reset` in 1: asynchronous, active-low reset (0 = in reset), from Clockworks `resetn`.
- `IO_memAddr` in 32: IO byte address; word address = `[15:2]`.
- `IO_memWData` in 32: write data.
- `IO_memWr` in 1: single-cycle write strobe.
- `IO_memRData` out 32: read data, combinational from address.
- `leds` out LED_W: LED register.
- `uart_wr` out 1: one-cycle byte-valid pulse to `txuart` `i_wr`.
- `uart_data` out 8: byte to `txuart` `i_data`, registered.
- `uart_busy` in 1: `txuart` `o_busy`.

## Operation
- Decode uses one-hot word-address bits, `wa = IO_memAddr[15:2]`. `wa[0]` selects LEDS (RW), `wa[1]` selects UART_DAT (W), `wa[2]` selects UART_CTRL (RW), `wa[3]` selects TIMER (R, see Configuration).
- Multiple set bits: the write applies to every selected register, and read data is the OR of the selected sources. No bit set: read 0, write ignored.
- LEDS: a write loads `leds <= WData[LED_W-1:0]`. A read returns the value zero-extended.
- UART_DAT: a write pushes `WData[7:0]` into the FIFO. A push while full is dropped and sets `ovf`.
- UART_CTRL read: bit9 = FIFO full, which keeps legacy firmware that polls bit9 working. bit8 = `done` (FIFO empty AND state IDLE AND !uart_busy). bit10 = `ovf`. `[24:16]` = FIFO level, 0..FIFO_DEPTH. All other bits are 0.
- UART_CTRL write: `WData[10]=1` clears `ovf`. A clear and an overflow in the same cycle leave `ovf` = 1.
- Drain FSM:
  - IDLE: if FIFO non-empty and !uart_busy, pop the head into `uart_data` and go to SEND.
  - SEND: `uart_wr` = 1 for exactly this cycle, then go to HOLD.
  - HOLD: ignore `uart_busy` for this one cycle to cover txuart's busy latency, then go to IDLE.
- FIFO ordering:
  - A push and a pop in the same cycle are both honoured, including when full (the pop frees a slot, so the push is accepted and `ovf` stays unchanged).
  - There is no bypass: a push into an empty FIFO is not poppable until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Level is kept as a separate counter of width $clog2(FIFO_DEPTH)+1.

## Timing
- Reset values: `leds` = 0, `uart_wr` = 0, `uart_data` = 0x00, FIFO empty (level 0), `ovf` = 0, state IDLE, timer 0, `IO_memRData` follows decode.
- Asserting reset mid-transmission discards FIFO contents and any byte in flight. `txuart` shares the same reset.
- A UART_DAT write in cycle N gives level +1 visible in N+1, and `uart_wr` high in N+2 if the engine is IDLE and not busy.
- Back-to-back bytes are issued no faster than one per 3 cycles and otherwise gated by `uart_busy`.
- An LEDS write in cycle N is visible on `leds` in N+1.
- Reads are zero-latency and reflect register state at the start of the cycle.

## Configuration
- `IO_HUB_TIMER_EN` defined: a 32-bit free-running counter increments every clk, wraps 0xFFFFFFFF→0, and is readable at `wa[3]`. Writes to `wa[3]` are ignored.
- `IO_HUB_TIMER_EN` undefined: no counter is built, and `wa[3]` reads 0.

## Structure
- Shared package `io_hub_pkg`:
  - word-bit constants `IO_LEDS_BIT`=0, `IO_UART_DAT_BIT`=1, `IO_UART_CTRL_BIT`=2, `IO_TIMER_BIT`=3;
  - status bit positions `ST_DONE`=8, `ST_FULL`=9, `ST_OVF`=10, `ST_LVL_LSB`=16;
  - drain-state encoding IDLE/SEND/HOLD.
- Sub-module `io_fifo`: synchronous FIFO, parameters WIDTH/DEPTH, providing push, pop, full, empty and level.

## Test plan
- Reset released: `leds`=0, `uart_wr`=0, CTRL read = 0x00000100 (done=1, level 0).
- Write 0xA5A5 to addr 0x4 → `leds`=0xA5A5 next cycle; read 0x4 returns 0x0000A5A5.
- Write 0x41 to addr 0x8 with `uart_busy`=0 → `uart_wr` pulses 2 cycles later with `uart_data`=0x41; hold busy 10 cycles → done=0 until busy falls, then CTRL bit8=1.
- Hold `uart_busy`=1 and push 17 bytes (DEPTH 16) → level=16, bit9=1, bit10=1; write 0x400 to addr 0x10 → bit10=0.
- Release busy after the FIFO fills → bytes exit in push order, never two `uart_wr` pulses less than 3 cycles apart; final level 0.
- With `IO_HUB_TIMER_EN`: two reads of addr 0x20 taken 5 cycles apart differ by 5. Without the macro, the read is 0.
